// File: rtl/dmem_responder_if.sv
// Data-memory request/response bundle between the core (master) and the
// memory responder (slave).
interface dmem_responder_if;
  logic        req;
  logic [31:0] addr;
  logic        we;
  logic [2:0]  mode;
  logic [31:0] wdata;
  logic        busy;
  logic        ready;
  logic [31:0] rdata;
  logic        err;

  modport master (output req, addr, we, mode, wdata,
                  input  busy, ready, rdata, err);
  modport slave  (input  req, addr, we, mode, wdata,
                  output busy, ready, rdata, err);
endinterface

// File: rtl/dmem_responder.sv
// Memory-side responder for the RV32I data bus: byte/half/word accesses with
// sign/zero extension, fault detection and a fixed, parameterised latency.
module dmem_responder #(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2
) (
  input logic            clk,
  input logic            reset,
  dmem_responder_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [31:0]   addr_q;
  logic          we_q;
  logic [2:0]    mode_q;
  logic [31:0]   wdata_q;

  logic [31:0]   mem [DEPTH];

  logic [31:0]   c_addr;
  logic          c_we;
  logic [2:0]    c_mode;
  logic [31:0]   c_wdata;
  logic [1:0]    lane;
  logic [AW-1:0] idx;
  logic [31:0]   word;
  logic [31:0]   shifted;
  logic [15:0]   half;
  logic [31:0]   load_val;
  logic [31:0]   wlane;
  logic [3:0]    be;
  logic [31:0]   new_word;
  logic          mode_ok;
  logic          fault;
  logic          commit;

  // Access decode for the transaction committing on this edge. With a single
  // cycle of latency the commit edge is the accept edge, so live bus inputs
  // are used instead of the latched copy.
  always_comb begin
    c_addr  = (LATENCY == 1) ? bus.addr  : addr_q;
    c_we    = (LATENCY == 1) ? bus.we    : we_q;
    c_mode  = (LATENCY == 1) ? bus.mode  : mode_q;
    c_wdata = (LATENCY == 1) ? bus.wdata : wdata_q;
    lane    = c_addr[1:0];
    idx     = c_addr[AW+1:2];
    word    = mem[idx];
    shifted = word >> {lane, 3'b000};
    half    = lane[1] ? word[31:16] : word[15:0];

    mode_ok  = 1'b1;
    load_val = '0;
    wlane    = c_wdata;
    be       = '0;
    case (c_mode)
      3'b000: begin
        load_val = {{24{shifted[7]}}, shifted[7:0]};
        wlane    = {4{c_wdata[7:0]}};
        be       = 4'b0001 << lane;
      end
      3'b001: begin
        load_val = {{16{half[15]}}, half};
        wlane    = {2{c_wdata[15:0]}};
        be       = lane[1] ? 4'b1100 : 4'b0011;
      end
      3'b010: begin
        load_val = word;
        be       = 4'b1111;
      end
      3'b100:  load_val = {24'h0, shifted[7:0]};
      3'b101:  load_val = {16'h0, half};
      default: mode_ok  = 1'b0;
    endcase

    fault = !mode_ok
         || (c_mode[1:0] == 2'b01 && lane[0])
         || (c_mode[1:0] == 2'b10 && lane != 2'b00)
         || ((c_addr >> (AW + 2)) != '0);

    for (int unsigned i = 0; i < 4; i++)
      new_word[i*8 +: 8] = be[i] ? wlane[i*8 +: 8] : word[i*8 +: 8];

    commit = !reset && ((state == WAIT && cnt == CW'(1))
                     || (LATENCY == 1 && state != WAIT && bus.req));
  end

  // Store commit; the array is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (commit && c_we && !fault)
      mem[idx] <= new_word;
  end

  // Request FSM with registered busy/ready/rdata/err.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      bus.busy  <= 1'b0;
      bus.ready <= 1'b0;
      bus.rdata <= '0;
      bus.err   <= 1'b0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      mode_q    <= '0;
      wdata_q   <= '0;
    end else begin
      case (state)
        WAIT: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state     <= RESP;
            bus.busy  <= 1'b0;
            bus.ready <= 1'b1;
          end
        end
        default: begin
          if (bus.req) begin
            addr_q  <= bus.addr;
            we_q    <= bus.we;
            mode_q  <= bus.mode;
            wdata_q <= bus.wdata;
            cnt     <= CW'(LATENCY - 1);
            if (LATENCY == 1) begin
              state     <= RESP;
              bus.busy  <= 1'b0;
              bus.ready <= 1'b1;
            end else begin
              state     <= WAIT;
              bus.busy  <= 1'b1;
              bus.ready <= 1'b0;
            end
          end else begin
            state     <= IDLE;
            bus.busy  <= 1'b0;
            bus.ready <= 1'b0;
          end
        end
      endcase
      if (commit) begin
        bus.rdata <= (fault || c_we) ? '0 : load_val;
        bus.err   <= fault;
      end
    end
  end

endmodule
